// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and constants for the sdp_ram_be memory slice.
package sdp_ram_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sdp_ram_clear_seq.sv
// sdp_ram_clear_seq: post-reset sequencer that walks every word once to zero the array.
module sdp_ram_clear_seq
    import sdp_ram_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt == LAST) ? READY : CLEAR;
        end
    end

    assign clear_we   = (state == CLEAR);
    assign clear_addr = cnt;
    assign init_busy  = (state == CLEAR);

endmodule

// File: rtl/sdp_ram_be.sv
// sdp_ram_be: simple-dual-port byte-enable RAM, zeroed by a clear sequence after reset.
// Define SDP_RAM_OUTREG_EN to add a second output register (2-cycle read latency).
module sdp_ram_be
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int RDW_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      init_busy
);

    localparam int                    NB      = byte_lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  wr_ok, rd_ok, wr_acc, rd_acc, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data, rd_word, rd_q;
    logic [NB-1:0]         mem_be;
    logic                  rd_valid_q;

    sdp_ram_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .init_busy  (init_busy)
    );

    assign wr_ok  = {1'b0, wr_addr} < DEPTH_W;
    assign rd_ok  = {1'b0, rd_addr} < DEPTH_W;
    assign wr_acc = !init_busy && wr_en && wr_ok;
    assign rd_acc = !init_busy && rd_en;

    // The clear sequencer owns the write port while it runs.
    assign mem_we   = clear_we || wr_acc;
    assign mem_addr = clear_we ? clear_addr : wr_addr;
    assign mem_be   = clear_we ? '1 : wr_be;
    assign mem_data = clear_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (mem_we && mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
    end

    always_comb begin
        rd_word = rd_ok ? mem[rd_addr] : '0;
        for (int i = 0; i < NB; i++)
            if (RDW_MODE == RDW_WRITE_FIRST && wr_acc && wr_addr == rd_addr && wr_be[i])
                rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_q <= rd_word;
        end
    end

`ifdef SDP_RAM_OUTREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_valid_q;
            if (rd_valid_q) rd_data <= rd_q;
        end
    end
`else
    assign rd_data  = rd_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb_sdp_ram_be: directed table-driven bench; instance a is 64-deep read-first, b is 48-deep write-first.
module tb_sdp_ram_be;

`ifdef SDP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [5:0]  wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .init_busy(busy_a)
    );

    sdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .init_busy(busy_b)
    );

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [5:0]  ra;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic wait_clear(input bit req_early, output int na, output int nb, output int early_valid);
        na = 0;
        nb = 0;
        early_valid = 0;
        for (int c = 1; c <= 200; c++) begin
            if (req_early && c < 20) begin
                wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 6'd5;
            end else idle();
            tick();
            if (rd_valid_a || rd_valid_b) early_valid++;
            if (!busy_a && na == 0) na = c;
            if (!busy_b && nb == 0) nb = c;
            if (na != 0 && nb != 0) break;
        end
        idle();
    endtask

    task automatic read_one(input logic [5:0] a, output logic [31:0] da, output logic [31:0] db,
                            output logic va, output logic vb);
        rd_en = 1'b1;
        rd_addr = a;
        tick();
        idle();
        repeat (LAT - 1) tick();
        da = rd_data_a; db = rd_data_b; va = rd_valid_a; vb = rd_valid_b;
    endtask

    initial begin
        int na, nb, ev, sweep_bad;
        logic [31:0] da, db, last_a, last_b;
        logic va, vb;

        vecs[0]  = '{1'b1, 6'd3,  32'h11223344, 4'hF,    1'b0, 6'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b1, 6'd3,  32'hAABBCCDD, 4'b0101, 1'b0, 6'd0,  32'h0,        32'h0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd3,  32'h11BB33DD, 32'h11BB33DD};
        vecs[3]  = '{1'b1, 6'd7,  32'h01020304, 4'hF,    1'b0, 6'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b1, 6'd7,  32'hFFFFFFFF, 4'b0011, 1'b1, 6'd7,  32'h01020304, 32'h0102FFFF};
        vecs[5]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd7,  32'h0102FFFF, 32'h0102FFFF};
        vecs[6]  = '{1'b1, 6'd50, 32'h5A5A5A5A, 4'hF,    1'b0, 6'd0,  32'h0,        32'h0};
        vecs[7]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd50, 32'h5A5A5A5A, 32'h0};
        vecs[8]  = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd47, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 6'd20, 32'hCAFEF00D, 4'h0,    1'b0, 6'd0,  32'h0,        32'h0};
        vecs[10] = '{1'b1, 6'd21, 32'h0BADF00D, 4'hF,    1'b1, 6'd20, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd21, 32'h0BADF00D, 32'h0BADF00D};
        vecs[12] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd5,  32'h0,        32'h0};
        vecs[13] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd63, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 6'd47, 32'h77665544, 4'b1000, 1'b0, 6'd0,  32'h0,        32'h0};
        vecs[15] = '{1'b0, 6'd0,  32'h0,        4'h0,    1'b1, 6'd47, 32'h77000000, 32'h77000000};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_rd_data_a", rd_data_a, 32'h0);
        chk("reset_rd_valid_a", {31'b0, rd_valid_a}, 32'h0);
        chk("reset_busy_a", {31'b0, busy_a}, 32'h1);
        chk("reset_busy_b", {31'b0, busy_b}, 32'h1);
        repeat (3) tick();
        rst_n = 1'b1;

        wait_clear(1'b1, na, nb, ev);
        chk("clear_cycles_a", na, 64);
        chk("clear_cycles_b", nb, 48);
        chk("no_valid_during_clear", ev, 0);
        tick();
        tick();

        sweep_bad = 0;
        for (int c = 0; c < 64 + LAT - 1; c++) begin
            rd_en = (c < 64);
            rd_addr = 6'(c);
            tick();
            if (c >= LAT - 1 &&
                (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || !rd_valid_a || !rd_valid_b))
                sweep_bad++;
        end
        idle();
        chk("sweep_all_zero_b2b", sweep_bad, 0);
        tick();
        chk("idle_valid_a", {31'b0, rd_valid_a}, 32'h0);
        last_a = 32'h0;
        last_b = 32'h0;

        for (int i = 0; i < 16; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_be = vecs[i].be;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            tick();
            idle();
            repeat (LAT - 1) tick();
            if (vecs[i].re) begin
                last_a = vecs[i].exp_a;
                last_b = vecs[i].exp_b;
            end
            chk($sformatf("vec%0d_data_a", i), rd_data_a, last_a);
            chk($sformatf("vec%0d_data_b", i), rd_data_b, last_b);
            chk($sformatf("vec%0d_valid_a", i), {31'b0, rd_valid_a}, {31'b0, vecs[i].re});
            chk($sformatf("vec%0d_valid_b", i), {31'b0, rd_valid_b}, {31'b0, vecs[i].re});
        end

        wr_en = 1'b1; wr_addr = 6'd10; wr_data = 32'h12345678; wr_be = 4'hF;
        tick();
        idle();
        read_one(6'd10, da, db, va, vb);
        chk("pre_reset_a10", da, 32'h12345678);
        chk("pre_reset_b10", db, 32'h12345678);
        rd_en = 1'b1; rd_addr = 6'd10;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid_a", {31'b0, rd_valid_a}, 32'h0);
        chk("async_reset_data_b", rd_data_b, 32'h0);
        chk("async_reset_busy_a", {31'b0, busy_a}, 32'h1);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        wait_clear(1'b0, na, nb, ev);
        chk("reclear_cycles_a", na, 64);
        chk("reclear_cycles_b", nb, 48);
        read_one(6'd10, da, db, va, vb);
        chk("post_reset_a10", da, 32'h0);
        chk("post_reset_b10", db, 32'h0);
        chk("post_reset_valid", {30'b0, va, vb}, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
